// File: rtl/lock_sequencer.sv
// Lock sequencer: queues acquire/release requests for NLOCKS locks and issues
// one legal lock/unlock op at a time on a valid/ready op-vector port.
module lock_sequencer #(
  parameter int NLOCKS    = 3,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic                                           req_op,
  input  logic [((NLOCKS > 1) ? $clog2(NLOCKS) : 1)-1:0] req_id,
  output logic                                           sys_valid,
  input  logic                                           sys_ready,
  output logic [2*NLOCKS-1:0]                            system,
  output logic [NLOCKS-1:0]                              monitor,
  output logic                                           err
);

  localparam int ID_W  = (NLOCKS > 1) ? $clog2(NLOCKS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] F_LOCK   = 2'b10;
  localparam logic [1:0] F_UNLOCK = 2'b11;

  typedef enum logic [1:0] {IDLE, HEAD, ISSUE} state_t;

  typedef struct packed {
    logic             op;
    logic [ID_W-1:0]  id;
    logic [RTY_W-1:0] retry;
  } entry_t;

  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return int'(id) < NLOCKS;
  endfunction

  function automatic logic lock_held(input logic [NLOCKS-1:0] mon,
                                     input logic [ID_W-1:0]   id);
    logic h;
    h = 1'b0;
    for (int i = 0; i < NLOCKS; i++) begin
      if (int'(id) == i) h = mon[i];
    end
    return h;
  endfunction

  // Lock 0 sits in the MSB field of the op vector.
  function automatic logic [2*NLOCKS-1:0] op_vector(input logic            op,
                                                    input logic [ID_W-1:0] id);
    logic [2*NLOCKS-1:0] v;
    v = '0;
    for (int i = 0; i < NLOCKS; i++) begin
      if (int'(id) == i) v[2*NLOCKS-1-2*i -: 2] = op ? F_UNLOCK : F_LOCK;
    end
    return v;
  endfunction

  function automatic logic [NLOCKS-1:0] mon_update(input logic [NLOCKS-1:0] mon,
                                                   input logic              op,
                                                   input logic [ID_W-1:0]   id);
    logic [NLOCKS-1:0] m;
    m = mon;
    for (int i = 0; i < NLOCKS; i++) begin
      if (int'(id) == i) m[i] = !op;
    end
    return m;
  endfunction

  state_t              state_q, state_d;
  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_d;
  entry_t              head, wr_entry;
  logic                head_ok, head_held, head_legal, in_head;
  logic                requeue_now, drop_now, issue_hs;
  logic                push, pop, wr_en;
  logic                vld_p1, err_p1;
  logic [2*NLOCKS-1:0] vec_p1;
  logic [NLOCKS-1:0]   mon_q;

  // Head classification and FIFO bookkeeping
  always_comb begin
    head        = mem[rd_ptr];
    head_ok     = id_in_range(head.id);
    head_held   = lock_held(mon_q, head.id);
    head_legal  = head_ok && (head.op ? head_held : !head_held);
    in_head     = (state_q == HEAD) && (count != '0);
    requeue_now = in_head && head_ok && !head.op && head_held &&
                  (head.retry < RTY_W'(MAX_RETRY));
    drop_now    = in_head && !head_legal && !requeue_now;
    issue_hs    = (state_q == ISSUE) && sys_ready;
    req_ready   = rst_n && (count < CNT_W'(DEPTH)) && !requeue_now;
    push        = req_valid && req_ready;
    pop         = requeue_now || drop_now || issue_hs;
    wr_en       = push || requeue_now;

    // A requeue owns the write port that cycle since req_ready is low.
    if (requeue_now) begin
      wr_entry.op    = head.op;
      wr_entry.id    = head.id;
      wr_entry.retry = head.retry + RTY_W'(1);
    end else begin
      wr_entry.op    = req_op;
      wr_entry.id    = req_id;
      wr_entry.retry = '0;
    end

    case ({wr_en, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count != '0) state_d = HEAD;
      end
      HEAD: begin
        if (count == '0)     state_d = IDLE;
        else if (head_legal) state_d = ISSUE;
        else if (drop_now)   state_d = (count_d != '0) ? HEAD : IDLE;
      end
      ISSUE: begin
        if (sys_ready) state_d = (count_d != '0) ? HEAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered control, op vector and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      mon_q   <= '0;
      vld_p1  <= 1'b0;
      vec_p1  <= '0;
      err_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      err_p1  <= drop_now;
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (in_head && head_legal) begin
        vld_p1 <= 1'b1;
        vec_p1 <= op_vector(head.op, head.id);
      end else if (issue_hs) begin
        vld_p1 <= 1'b0;
        vec_p1 <= '0;
        mon_q  <= mon_update(mon_q, head.op, head.id);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  assign sys_valid = vld_p1;
  assign system    = vec_p1;
  assign monitor   = mon_q;
  assign err       = err_p1;

endmodule

// File: tb/tb_lock_sequencer.sv
// Randomized bench for lock_sequencer with a queue-based reference model and a
// scoreboard checked by a separate negedge monitor.
module tb_lock_sequencer;

  localparam int NL    = 3;
  localparam int DEPTH = 4;
  localparam int MR    = 2;
  localparam int ID_W  = 2;
  localparam int VW    = 2 * NL;
  localparam int PH_IDLE  = 0;
  localparam int PH_HEAD  = 1;
  localparam int PH_ISSUE = 2;

  logic            clk = 1'b0;
  logic            rst_n, req_valid, req_ready, req_op;
  logic            sys_valid, sys_ready, err;
  logic [ID_W-1:0] req_id;
  logic [VW-1:0]   system;
  logic [NL-1:0]   monitor;

  always #5 clk = ~clk;

  lock_sequencer #(.NLOCKS(NL), .DEPTH(DEPTH), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_id(req_id), .sys_valid(sys_valid),
    .sys_ready(sys_ready), .system(system), .monitor(monitor), .err(err)
  );

  typedef struct { bit op; int id; int retry; } ent_t;
  typedef struct { bit is_err; logic [VW-1:0] vec; logic [NL-1:0] mon; } exp_t;

  ent_t          q[$];
  exp_t          sb[$];
  bit            held[NL];
  int            phase = PH_IDLE;
  logic [VW-1:0] m_vec = '0;
  bit            m_vld = 1'b0;
  bit            m_err = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic logic [VW-1:0] vec_of(bit op, int id);
    logic [VW-1:0] v;
    v = '0;
    v[VW-1-2*id -: 2] = op ? 2'b11 : 2'b10;
    return v;
  endfunction

  function automatic logic [NL-1:0] held_vec();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = held[i];
    return v;
  endfunction

  function automatic bit will_requeue();
    if (phase != PH_HEAD || q.size() == 0) return 1'b0;
    if (q[0].op || q[0].id >= NL) return 1'b0;
    return held[q[0].id] && (q[0].retry < MR);
  endfunction

  function automatic bit exp_ready();
    return rst_n && (q.size() < DEPTH) && !will_requeue();
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: queue of pending requests plus a held-lock table.
  always @(posedge clk) begin : model
    ent_t h;
    exp_t e;
    bit   acc, legal, nerr, decide;
    int   nxt;
    if (!rst_n) begin
      q.delete();
      sb.delete();
      for (int i = 0; i < NL; i++) held[i] = 1'b0;
      phase = PH_IDLE;
      m_vld = 1'b0;
      m_vec = '0;
      m_err = 1'b0;
    end else begin
      acc    = req_valid && exp_ready();
      nerr   = 1'b0;
      decide = 1'b0;
      nxt    = phase;
      if (phase == PH_IDLE) begin
        if (q.size() != 0) nxt = PH_HEAD;
      end else if (phase == PH_HEAD) begin
        if (q.size() == 0) nxt = PH_IDLE;
        else begin
          h = q[0];
          legal = 1'b0;
          if (h.id < NL) legal = h.op ? held[h.id] : !held[h.id];
          if (legal) begin
            m_vld    = 1'b1;
            m_vec    = vec_of(h.op, h.id);
            e.is_err = 1'b0;
            e.vec    = m_vec;
            e.mon    = held_vec();
            e.mon[h.id] = !h.op;
            sb.push_back(e);
            nxt = PH_ISSUE;
          end else if (will_requeue()) begin
            void'(q.pop_front());
            h.retry++;
            q.push_back(h);
          end else begin
            void'(q.pop_front());
            nerr     = 1'b1;
            e.is_err = 1'b1;
            e.vec    = '0;
            e.mon    = held_vec();
            sb.push_back(e);
            decide   = 1'b1;
          end
        end
      end else begin
        if (sys_ready) begin
          h = q.pop_front();
          held[h.id] = !h.op;
          m_vld  = 1'b0;
          m_vec  = '0;
          decide = 1'b1;
        end
      end
      if (acc) begin
        h.op = req_op; h.id = int'(req_id); h.retry = 0;
        q.push_back(h);
      end
      if (decide) nxt = (q.size() != 0) ? PH_HEAD : PH_IDLE;
      phase = nxt;
      m_err = nerr;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pops on DUT events.
  logic [NL-1:0] pend_mon;
  bit            pend = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (pend) begin
      chk("monitor_after_handshake", monitor, pend_mon);
      pend = 1'b0;
    end
    chk("req_ready", req_ready, exp_ready());
    chk("sys_valid", sys_valid, m_vld);
    chk("system", system, m_vec);
    chk("monitor", monitor, held_vec());
    chk("err", err, m_err);
    if (err) begin
      chk("sb_has_err", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_kind_err", e.is_err, 1);
      end
    end
    if (sys_valid && sys_ready && rst_n) begin
      chk("sb_has_issue", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_kind_issue", e.is_err, 0);
        chk("sb_vec", system, e.vec);
        pend_mon = e.mon;
        pend     = 1'b1;
      end
    end
  end

  task automatic cyc(bit v, bit op, int id, bit sr, bit rn);
    @(posedge clk);
    #1;
    req_valid = v;
    req_op    = op;
    req_id    = ID_W'(id);
    sys_ready = sr;
    rst_n     = rn;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_id = '0; sys_ready = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 1, 1); idle(6);               // acquire lock 0
    cyc(1, 1, 0, 1, 1); idle(6);               // release lock 0
    cyc(1, 1, 1, 1, 1); idle(5);               // release of unheld lock 1
    cyc(1, 0, 0, 1, 1); idle(6);               // hold lock 0 again
    cyc(1, 0, 0, 0, 1); cyc(1, 1, 0, 0, 1); idle(14);
    cyc(1, 0, 2, 1, 1); idle(6);               // hold lock 2
    cyc(1, 0, 2, 1, 1); idle(14);              // requeued twice then dropped
    cyc(1, 0, 1, 0, 1); cyc(1, 0, 1, 0, 1); cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); cyc(1, 3, 1, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0); cyc(1, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0);
    idle(4);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), $urandom_range(0, 99) < 70,
          $urandom_range(0, 299) != 0);
    idle(40);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
